// File: rtl/ant_step_scheduler_pkg.sv
// Shared parameters, types and direction lookup for the ant step scheduler.
package ant_step_scheduler_pkg;

    localparam int ANT_num      = 16;
    localparam int ANT_num_bits = 4;
    localparam int X_bits       = 8;
    localparam int Y_bits       = 7;
    localparam int PIXELS_X     = 160;
    localparam int PIXELS_Y     = 120;

    // Screen coordinates: north is decreasing y.
    typedef enum logic [2:0] {
        DIR_E  = 3'd0,
        DIR_NE = 3'd1,
        DIR_N  = 3'd2,
        DIR_NW = 3'd3,
        DIR_W  = 3'd4,
        DIR_SW = 3'd5,
        DIR_S  = 3'd6,
        DIR_SE = 3'd7
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_PROPOSE,
        S_CHECK,
        S_WRITE,
        S_NEXT
    } sched_state_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input dir_e dir);
        delta_t d;
        case (dir)
            DIR_E:   d = '{dx:  2'sd1, dy:  2'sd0};
            DIR_NE:  d = '{dx:  2'sd1, dy: -2'sd1};
            DIR_N:   d = '{dx:  2'sd0, dy: -2'sd1};
            DIR_NW:  d = '{dx: -2'sd1, dy: -2'sd1};
            DIR_W:   d = '{dx: -2'sd1, dy:  2'sd0};
            DIR_SW:  d = '{dx: -2'sd1, dy:  2'sd1};
            DIR_S:   d = '{dx:  2'sd0, dy:  2'sd1};
            default: d = '{dx:  2'sd1, dy:  2'sd1};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ant_step_scheduler_if.sv
// Ant-state memory port plus the shared collision-lookup port.
interface ant_step_scheduler_if;
    import ant_step_scheduler_pkg::*;

    logic [ANT_num_bits-1:0] ant_id;
    logic                    ant_rd_en;
    logic                    ant_rd_valid;
    logic [X_bits-1:0]       ant_x_in;
    logic [Y_bits-1:0]       ant_y_in;
    logic [2:0]              ant_dir_in;
    logic                    ant_we;
    logic [X_bits-1:0]       ant_x_out;
    logic [Y_bits-1:0]       ant_y_out;
    logic [2:0]              ant_dir_out;
    logic [X_bits-1:0]       collide_x;
    logic [Y_bits-1:0]       collide_y;
    logic                    collision;

    modport master (
        output ant_id, ant_rd_en, ant_we, ant_x_out, ant_y_out, ant_dir_out,
               collide_x, collide_y,
        input  ant_rd_valid, ant_x_in, ant_y_in, ant_dir_in, collision
    );

    modport slave (
        input  ant_id, ant_rd_en, ant_we, ant_x_out, ant_y_out, ant_dir_out,
               collide_x, collide_y,
        output ant_rd_valid, ant_x_in, ant_y_in, ant_dir_in, collision
    );

endinterface

// File: rtl/ant_move_calc.sv
// Combinational move proposal, bounds test and blocked-turn resolution for one ant.
module ant_move_calc
    import ant_step_scheduler_pkg::*;
(
    input  logic [X_bits-1:0]        x,
    input  logic [Y_bits-1:0]        y,
    input  logic [2:0]               dir,
    input  logic                     collision,
    input  logic                     rand_bit,
    output logic signed [X_bits:0]   nx,
    output logic signed [Y_bits:0]   ny,
    output logic                     out_of_bounds,
    output logic [X_bits-1:0]        new_x,
    output logic [Y_bits-1:0]        new_y,
    output logic [2:0]               new_dir
);

    localparam logic signed [X_bits:0] X_MAX = (X_bits+1)'(PIXELS_X - 1);
    localparam logic signed [Y_bits:0] Y_MAX = (Y_bits+1)'(PIXELS_Y - 1);

    delta_t d;
    logic   blocked;

    always_comb begin
        d  = dir_delta(dir_e'(dir));
        nx = $signed({1'b0, x}) + $signed({{(X_bits-1){d.dx[1]}}, d.dx});
        ny = $signed({1'b0, y}) + $signed({{(Y_bits-1){d.dy[1]}}, d.dy});
        out_of_bounds = nx[X_bits] || (nx > X_MAX) || ny[Y_bits] || (ny > Y_MAX);
        blocked = out_of_bounds || collision;
        // Blocked ants stay put and turn one step either way (+7 == -1 mod 8).
        if (blocked) begin
            new_x   = x;
            new_y   = y;
            new_dir = rand_bit ? (dir + 3'd1) : (dir + 3'd7);
        end else begin
            new_x   = nx[X_bits-1:0];
            new_y   = ny[Y_bits-1:0];
            new_dir = dir;
        end
    end

endmodule

// File: rtl/ant_step_scheduler.sv
// Walks every ant once per tick: read, propose, collision check, write back.
module ant_step_scheduler
    import ant_step_scheduler_pkg::*;
(
    input  logic                   setup_clk,
    input  logic                   RESET_SIM,
    input  logic                   SETUP_MODE,
    input  logic                   tick,
    input  logic [7:0]             rand_val,
    ant_step_scheduler_if.master   ant_bus,
    output logic                   busy,
    output logic                   step_done,
    output logic [7:0]             overrun_cnt
);

    localparam logic [ANT_num_bits-1:0] LAST_ID = ANT_num_bits'(ANT_num - 1);

    sched_state_e            state;
    logic [ANT_num_bits-1:0] id_q;
    logic                    rd_en_q;
    logic                    we_q;
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              overrun_q;
    logic [X_bits-1:0]       x_q;
    logic [Y_bits-1:0]       y_q;
    logic [2:0]              dir_q;
    logic [X_bits-1:0]       cx_q;
    logic [Y_bits-1:0]       cy_q;

    logic signed [X_bits:0]  nx;
    logic signed [Y_bits:0]  ny;
    logic                    oob;
    logic [X_bits-1:0]       new_x;
    logic [Y_bits-1:0]       new_y;
    logic [2:0]              new_dir;
    logic                    unused_ok;

    ant_move_calc u_calc (
        .x             (x_q),
        .y             (y_q),
        .dir           (dir_q),
        .collision     (ant_bus.collision),
        .rand_bit      (rand_val[0]),
        .nx            (nx),
        .ny            (ny),
        .out_of_bounds (oob),
        .new_x         (new_x),
        .new_y         (new_y),
        .new_dir       (new_dir)
    );

    always_ff @(posedge setup_clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state     <= S_IDLE;
            id_q      <= '0;
            rd_en_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
        end else begin
            rd_en_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;

            if (tick && !SETUP_MODE && state != S_IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;

            // Initializer takes the resources back: abandon the step silently.
            if (SETUP_MODE && state != S_IDLE) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                id_q   <= '0;
                cx_q   <= '0;
                cy_q   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tick && !SETUP_MODE) begin
                            state   <= S_FETCH;
                            id_q    <= '0;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end
                    S_FETCH: state <= S_WAIT_RD;
                    S_WAIT_RD: begin
                        if (ant_bus.ant_rd_valid) begin
                            x_q   <= ant_bus.ant_x_in;
                            y_q   <= ant_bus.ant_y_in;
                            dir_q <= ant_bus.ant_dir_in;
                            state <= S_PROPOSE;
                        end
                    end
                    S_PROPOSE: begin
                        cx_q  <= oob ? '0 : nx[X_bits-1:0];
                        cy_q  <= oob ? '0 : ny[Y_bits-1:0];
                        state <= S_CHECK;
                    end
                    // Collision answer arrives during WRITE and feeds the write data directly.
                    S_CHECK: begin
                        cx_q  <= '0;
                        cy_q  <= '0;
                        we_q  <= 1'b1;
                        state <= S_WRITE;
                    end
                    S_WRITE: begin
                        done_q <= (id_q == LAST_ID);
                        state  <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (id_q == LAST_ID) begin
                            id_q   <= '0;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            id_q    <= id_q + 1'b1;
                            rd_en_q <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ant_bus.ant_id      = id_q;
    assign ant_bus.ant_rd_en   = rd_en_q;
    assign ant_bus.ant_we      = we_q & ~SETUP_MODE;
    assign ant_bus.ant_x_out   = (state == S_WRITE) ? new_x   : '0;
    assign ant_bus.ant_y_out   = (state == S_WRITE) ? new_y   : '0;
    assign ant_bus.ant_dir_out = (state == S_WRITE) ? new_dir : '0;
    assign ant_bus.collide_x   = cx_q;
    assign ant_bus.collide_y   = cy_q;

    assign busy        = busy_q;
    assign step_done   = done_q & ~SETUP_MODE;
    assign overrun_cnt = overrun_q;

    assign unused_ok = ^{rand_val[7:1], nx[X_bits], ny[Y_bits]};

endmodule

// File: tb/tb_ant_step_scheduler.sv
// Scoreboard bench: stimulus queues expected write-backs, a monitor checks each ant_we.
module tb_ant_step_scheduler;
    import ant_step_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setup_mode = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] rand_val = 8'd0;
    logic       busy;
    logic       step_done;
    logic [7:0] overrun_cnt;

    ant_step_scheduler_if bus();

    ant_step_scheduler dut (
        .setup_clk   (clk),
        .RESET_SIM   (rst),
        .SETUP_MODE  (setup_mode),
        .tick        (tick),
        .rand_val    (rand_val),
        .ant_bus     (bus),
        .busy        (busy),
        .step_done   (step_done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id; int x; int y; int d; int cx; int cy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem_x [16];
    logic [6:0] mem_y [16];
    logic [2:0] mem_d [16];
    logic       blk_en = 1'b0;
    logic [7:0] blk_x = 8'd0;
    logic [6:0] blk_y = 7'd0;
    int         rd_delay = 1;
    int         wr_in_step = 0;
    int         rd_en_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic set_ant(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] d);
        mem_x[i] = x; mem_y[i] = y; mem_d[i] = d;
    endtask

    task automatic expect_wr(input int id, input int x, input int y, input int d, input int cx, input int cy);
        exp_t e;
        e = '{id: id, x: x, y: y, d: d, cx: cx, cy: cy};
        exp_q.push_back(e);
    endtask

    // Filler ants head south from (100, 10+i): dir 6 is (0,+1).
    task automatic load_default();
        for (int i = 0; i < 16; i++) set_ant(i, 8'd100, 7'(10 + i), 3'd6);
    endtask

    task automatic push_default(input int from);
        for (int i = from; i < 16; i++) expect_wr(i, 100, 11 + i, 6, 100, 11 + i);
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!step_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!step_done) begin
            n_cmp++; n_bad++;
            $display("FAIL step_done_timeout: got no step_done within %0d cycles", budget);
        end
    endtask

    // Memory and collision responder.
    initial begin
        logic       pend_hit;
        logic [3:0] rd_id;
        int         rd_cnt;
        pend_hit = 1'b0; rd_id = 4'd0; rd_cnt = 0;
        bus.ant_rd_valid = 1'b0;
        bus.ant_x_in = '0; bus.ant_y_in = '0; bus.ant_dir_in = '0;
        bus.collision = 1'b0;
        forever begin
            @(negedge clk);
            pend_hit = blk_en && bus.collide_x == blk_x && bus.collide_y == blk_y;
            if (bus.ant_rd_en) begin
                rd_cnt = rd_delay;
                rd_id  = bus.ant_id;
            end
            @(posedge clk); #1;
            bus.collision    = pend_hit;
            bus.ant_rd_valid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    bus.ant_rd_valid = 1'b1;
                    bus.ant_x_in     = mem_x[rd_id];
                    bus.ant_y_in     = mem_y[rd_id];
                    bus.ant_dir_in   = mem_d[rd_id];
                end
            end
        end
    end

    // Monitor: pops an expectation on every write strobe.
    initial begin
        exp_t       e;
        logic [7:0] pcx;
        logic [6:0] pcy;
        pcx = '0; pcy = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ant_rd_en) rd_en_seen++;
                if (bus.ant_we) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: got write for ant %0d expected none", bus.ant_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_id",       32'(bus.ant_id),      e.id);
                        chk("wr_x",        32'(bus.ant_x_out),   e.x);
                        chk("wr_y",        32'(bus.ant_y_out),   e.y);
                        chk("wr_dir",      32'(bus.ant_dir_out), e.d);
                        chk("check_cx",    32'(pcx),             e.cx);
                        chk("check_cy",    32'(pcy),             e.cy);
                        chk("rd_en_pulses", rd_en_seen,          1);
                        chk("busy_on_write", 32'(busy),          1);
                    end
                    rd_en_seen = 0;
                    wr_in_step++;
                end else if (!setup_mode) begin
                    chk("wr_data_idle_zero",
                        32'({bus.ant_x_out, bus.ant_y_out, bus.ant_dir_out}), 0);
                end
                if (step_done) begin
                    chk("writes_per_step", wr_in_step, 16);
                    wr_in_step = 0;
                end
                pcx = bus.collide_x;
                pcy = bus.collide_y;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        load_default();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",    32'(busy),          0);
        chk("rst_done",    32'(step_done),     0);
        chk("rst_overrun", 32'(overrun_cnt),   0);
        chk("rst_id",      32'(bus.ant_id),    0);
        chk("rst_rd_en",   32'(bus.ant_rd_en), 0);
        chk("rst_collide", 32'({bus.collide_x, bus.collide_y}), 0);

        // Step A: mixed moves, bounds, a collision; three overrun ticks.
        rand_val = 8'd1; blk_en = 1'b1; blk_x = 8'd20; blk_y = 7'd19; rd_delay = 1;
        load_default();
        set_ant(0, 8'd10,  7'd10,  3'd0); expect_wr(0, 11, 10, 0, 11, 10);
        set_ant(1, 8'd159, 7'd50,  3'd0); expect_wr(1, 159, 50, 1, 0, 0);
        set_ant(2, 8'd20,  7'd20,  3'd2); expect_wr(2, 20, 20, 3, 20, 19);
        set_ant(3, 8'd0,   7'd0,   3'd3); expect_wr(3, 0, 0, 4, 0, 0);
        set_ant(4, 8'd5,   7'd119, 3'd5); expect_wr(4, 5, 119, 6, 0, 0);
        set_ant(5, 8'd50,  7'd60,  3'd7); expect_wr(5, 51, 61, 7, 51, 61);
        set_ant(6, 8'd50,  7'd60,  3'd4); expect_wr(6, 49, 60, 4, 49, 60);
        set_ant(7, 8'd30,  7'd0,   3'd1); expect_wr(7, 30, 0, 2, 0, 0);
        push_default(8);
        pulse_tick();
        chk("busy_after_tick_a", 32'(busy), 1);
        repeat (10) @(posedge clk);
        pulse_tick(); pulse_tick(); pulse_tick();
        wait_done(2000);
        repeat (5) @(negedge clk);
        chk("no_restart_busy_a", 32'(busy),        0);
        chk("overrun_a",         32'(overrun_cnt), 3);
        chk("queue_empty_a",     exp_q.size(),     0);

        // Step B: slow reads, rand bit 0, tick coinciding with step_done.
        rand_val = 8'd0; blk_en = 1'b0; rd_delay = 7;
        load_default();
        set_ant(0, 8'd159, 7'd50,  3'd0); expect_wr(0, 159, 50, 7, 0, 0);
        set_ant(1, 8'd0,   7'd60,  3'd4); expect_wr(1, 0, 60, 3, 0, 0);
        set_ant(2, 8'd80,  7'd119, 3'd6); expect_wr(2, 80, 119, 5, 0, 0);
        push_default(3);
        pulse_tick();
        chk("busy_after_tick_b", 32'(busy), 1);
        wait_done(3000);
        tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_restart_busy_b", 32'(busy),        0);
        chk("overrun_b",         32'(overrun_cnt), 4);
        chk("queue_empty_b",     exp_q.size(),     0);

        // Step C: SETUP_MODE during ant 2's CHECK aborts before its write.
        rand_val = 8'd1; rd_delay = 1;
        load_default();
        set_ant(2, 8'd40, 7'd40, 3'd0);
        push_default(0);
        exp_q.delete(2);
        while (exp_q.size() > 2) exp_q.delete(2);
        pulse_tick();
        k = 0;
        @(negedge clk);
        while (!(bus.ant_id == 4'd2 && bus.collide_x != 8'd0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_check_cx", 32'(bus.collide_x), 41);
        setup_mode = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy),        0);
        chk("abort_id",   32'(bus.ant_id),  0);
        chk("abort_done", 32'(step_done),   0);
        chk("abort_we",   32'(bus.ant_we),  0);
        pulse_tick();
        repeat (3) @(negedge clk);
        chk("setup_tick_busy",    32'(busy),        0);
        chk("setup_tick_overrun", 32'(overrun_cnt), 4);
        @(posedge clk); #1;
        setup_mode = 1'b0;
        rd_en_seen = 0; wr_in_step = 0;
        chk("queue_empty_c", exp_q.size(), 0);

        // Step D: reset mid-step, then a clean full step.
        load_default();
        push_default(0);
        pulse_tick();
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",    32'(busy),          0);
        chk("midrst_overrun", 32'(overrun_cnt),   0);
        chk("midrst_we",      32'(bus.ant_we),    0);
        chk("midrst_rd_en",   32'(bus.ant_rd_en), 0);
        chk("midrst_id",      32'(bus.ant_id),    0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        rd_en_seen = 0; wr_in_step = 0;
        repeat (3) @(posedge clk);
        push_default(0);
        pulse_tick();
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk("overrun_d",     32'(overrun_cnt), 0);
        chk("busy_end_d",    32'(busy),        0);
        chk("queue_empty_d", exp_q.size(),     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
